uart_tx_param: RTL and testbench

//   Parametrised UART transmitter; next generation of the fixed 8-bit TX path.
//   - Serialises DATA_BITS-wide words LSB-first with an internal baud divider.
//   - Frame format: start bit, data bits, optional even/odd parity, then 1 or 2 stop bits.
//   - One-entry holding buffer with valid/ready handshake, so back-to-back frames leave no idle gap.
//   - Sits between the host-side producer and the serial line driver.

---
 rtl/uart_tx_param.sv | 133 +++++++++++++
 tb/tb_uart_tx_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding buffer.
// Frame: start, DATA_BITS LSB-first, optional parity, 1 or 2 stops.
module uart_tx_param #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 baurd_clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 fout,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic ODD = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state, state_nxt;

   logic [TW-1:0]        timer;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] hold;
   logic [DATA_BITS-1:0] shift;
   logic                 hold_full;
   logic                 par;
   logic                 bit_end;
   logic                 accept;
   logic                 xfer;
   logic                 load;

   assign bit_end  = (timer == '0);
   assign accept   = tx_valid & ~hold_full;
   assign tx_ready = ~hold_full;
   assign busy     = (state != IDLE);

   always_ff @(posedge baurd_clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      fout       = 1'b1;
      frame_done = 1'b0;
      xfer       = 1'b0;
      unique case (state)
         IDLE: begin
            if (hold_full) begin
               state_nxt = START;
               xfer      = 1'b1;
            end
         end
         START: begin
            fout = 1'b0;
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            fout = shift[0];
            if (bit_end && bit_cnt == LAST_BIT)
               state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
         end
         PARITY: begin
            fout = par;
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end && stop_cnt == LAST_STOP) begin
               frame_done = 1'b1;
               // A waiting word starts immediately: no idle gap.
               if (hold_full) begin
                  state_nxt = START;
                  xfer      = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load = (state_nxt != state) || (state != IDLE && bit_end);

   always_ff @(posedge baurd_clk) begin
      if (!reset) begin
         timer     <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         hold      <= '0;
         shift     <= '0;
         hold_full <= 1'b0;
         par       <= 1'b0;
      end else begin
         hold_full <= (hold_full & ~xfer) | accept;
         if (accept) hold <= tx_data;
         if (xfer) begin
            shift <= hold;
            par   <= ^hold ^ ODD;
         end
         if (load)              timer <= TMAX;
         else if (state != IDLE) timer <= timer - 1'b1;
         if (state == START) begin
            bit_cnt <= '0;
         end else if (state == DATA && bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= shift >> 1;
         end
         if (state != STOP)
            stop_cnt <= 1'b0;
         else if (bit_end && stop_cnt != LAST_STOP)
            stop_cnt <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations, queued expected
// frames from a bit-list model, per-instance line monitors.
module tb_uart_tx_param;

   localparam int CPB = 4;
   localparam int DB [3] = '{8, 8, 7};
   localparam int PE [3] = '{1, 1, 0};
   localparam int PO [3] = '{0, 1, 0};
   localparam int SB [3] = '{1, 1, 2};

   typedef struct {
      logic [15:0] bits;
      int          nb;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] valid_a = '0;
   logic [8:0] data_a [3];
   wire  [2:0] ready_a;
   wire  [2:0] fout_a;
   wire  [2:0] busy_a;
   wire  [2:0] fd_a;

   frame_t exp_q [3][$];
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   uart_tx_param #(8, CPB, 1, 0, 1) u0 (
      .baurd_clk(clk), .reset(rst_n),
      .tx_valid(valid_a[0]), .tx_data(data_a[0][7:0]),
      .tx_ready(ready_a[0]), .fout(fout_a[0]),
      .busy(busy_a[0]), .frame_done(fd_a[0]));

   uart_tx_param #(8, CPB, 1, 1, 1) u1 (
      .baurd_clk(clk), .reset(rst_n),
      .tx_valid(valid_a[1]), .tx_data(data_a[1][7:0]),
      .tx_ready(ready_a[1]), .fout(fout_a[1]),
      .busy(busy_a[1]), .frame_done(fd_a[1]));

   uart_tx_param #(7, CPB, 0, 0, 2) u2 (
      .baurd_clk(clk), .reset(rst_n),
      .tx_valid(valid_a[2]), .tx_data(data_a[2][6:0]),
      .tx_ready(ready_a[2]), .fout(fout_a[2]),
      .busy(busy_a[2]), .frame_done(fd_a[2]));

   // Expected line levels, one entry per serial bit.
   function automatic frame_t model(int k, int d);
      frame_t f;
      int n;
      int ones;
      f.bits = '1;
      f.bits[0] = 1'b0;
      n = 1;
      ones = 0;
      for (int i = 0; i < DB[k]; i++) begin
         f.bits[n] = 1'((d >> i) & 1);
         ones += (d >> i) & 1;
         n++;
      end
      if (PE[k] != 0) begin
         f.bits[n] = 1'((ones % 2) ^ PO[k]);
         n++;
      end
      f.nb = n + SB[k];
      return f;
   endfunction

   task automatic chk(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic send(int k, int d);
      @(negedge clk);
      valid_a[k] = 1'b1;
      data_a[k] = 9'(d);
      for (int i = 0; i < 300 && !ready_a[k]; i++) @(negedge clk);
      if (!ready_a[k]) begin
         total++;
         bad++;
         $display("FAIL send_timeout dut%0d actual=not_ready required=ready", k);
         valid_a[k] = 1'b0;
      end else begin
         exp_q[k].push_back(model(k, d));
         @(posedge clk);
         #1;
         valid_a[k] = 1'b0;
      end
   endtask

   task automatic drain();
      int i;
      int pend;
      i = 0;
      pend = 1;
      while (i < 3000 && pend != 0) begin
         @(negedge clk);
         pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size()
              + int'(busy_a != 3'b000);
         i++;
      end
      chk("drain_pending", pend, 0);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_mon
      initial begin
         frame_t e;
         int len;
         int nerr;
         int fc;
         logic [2:0] fa;
         logic [2:0] fx;
         bit ab;
         forever begin
            @(negedge clk);
            if (rst_n && busy_a[g]) begin
               if (exp_q[g].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame dut%0d actual=busy required=idle", g);
                  while (busy_a[g] && rst_n) @(negedge clk);
               end else begin
                  e = exp_q[g].pop_front();
                  len = e.nb * CPB;
                  nerr = 0;
                  ab = 1'b0;
                  fc = -1;
                  fa = '0;
                  fx = '0;
                  for (int c = 0; c < len; c++) begin
                     if (c > 0) @(negedge clk);
                     if (!rst_n) begin
                        ab = 1'b1;
                        break;
                     end
                     if (fout_a[g] !== e.bits[c / CPB] || busy_a[g] !== 1'b1
                         || fd_a[g] !== (c == len - 1)) begin
                        if (nerr == 0) begin
                           fc = c;
                           fa = {fout_a[g], busy_a[g], fd_a[g]};
                           fx = {e.bits[c / CPB], 1'b1, (c == len - 1)};
                        end
                        nerr++;
                     end
                  end
                  if (!ab) begin
                     total++;
                     if (nerr != 0) begin
                        bad++;
                        $display("FAIL frame dut%0d cycle=%0d fout/busy/done actual=%03b required=%03b errs=%0d",
                                 g, fc, fa, fx, nerr);
                     end
                  end
               end
            end else if (rst_n && fd_a[g]) begin
               total++;
               bad++;
               $display("FAIL spurious_done dut%0d actual=1 required=0", g);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int viol;
      int rdy_hi;
      int seen;
      int d;
      for (int k = 0; k < 3; k++) data_a[k] = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_fout", fout_a[0], 1);
      chk("rst_ready", ready_a[0], 1);
      chk("rst_busy", busy_a[0], 0);
      chk("rst_done", fd_a[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         if (fout_a != 3'b111 || ready_a != 3'b111 || busy_a != 3'b000)
            viol++;
      end
      chk("idle_stable", viol, 0);

      // single frame, even parity
      send(0, 8'h55);
      drain();

      // odd parity instance
      send(1, 8'h07);
      send(1, 8'h03);
      drain();

      // back-to-back frames
      send(0, 8'hA3);
      send(0, 8'h3C);
      rdy_hi = 0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fd_a[0]) begin
            seen = 1;
            break;
         end
         if (ready_a[0]) rdy_hi++;
      end
      chk("b2b_done_seen", seen, 1);
      chk("b2b_ready_low", rdy_hi, 0);
      @(negedge clk);
      chk("b2b_start_fout", fout_a[0], 0);
      chk("b2b_start_busy", busy_a[0], 1);
      chk("b2b_ready_back", ready_a[0], 1);
      drain();

      // 7 data bits, no parity, 2 stops
      send(2, 7'h41);
      drain();

      // randomized traffic
      for (int n = 0; n < 25; n++) begin
         d = int'($urandom_range(0, 255));
         send(0, d);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 60)) @(negedge clk);
      end
      for (int n = 0; n < 6; n++) begin
         send(1, int'($urandom_range(0, 255)));
         send(2, int'($urandom_range(0, 127)));
      end
      drain();

      // reset in the middle of the data bits
      send(0, 8'hFF);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_fout", fout_a[0], 1);
      chk("abort_busy", busy_a[0], 0);
      chk("abort_ready", ready_a[0], 1);
      viol = 0;
      repeat (2) begin
         @(negedge clk);
         if (fd_a[0] || fout_a[0] != 1'b1) viol++;
      end
      chk("abort_quiet", viol, 0);
      for (int k = 0; k < 3; k++) exp_q[k].delete();
      rst_n = 1'b1;
      send(0, 8'h81);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
